// File: rtl/apb_pkg.sv
// Definitions shared by the APB master and the APB register-file completer.
package apb_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;

  // The master walks all three states; the completer uses only idle and access.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the team's APB master and a completer.
interface apb_slave_regfile_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DataW-1:0]  PWDATA;
  logic [StrbW-1:0]  PSTRB;
  logic [DataW-1:0]  PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_regbank.sv
// NUM_REGS x 32-bit register storage with byte-strobe writes and a combinational read mux.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [IDX_W-1:0]          idx,
  input  logic [StrbW-1:0]          wstrb,
  input  logic [DataW-1:0]          wdata,
  output logic [DataW-1:0]          rdata,
  output logic [NUM_REGS*DataW-1:0] regs
);

  logic [DataW-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(idx) == i) begin
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (wstrb[b]) begin
              mem_q[i][8*b +: 8] <= wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Out-of-range indices select nothing and read as zero.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) begin
        rdata = mem_q[i];
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs[DataW*i +: DataW] = mem_q[i];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer fronting a byte-strobed register file with range/alignment error reporting.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states per access.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  apb_slave_regfile_if.slave        apb,
  output logic [NUM_REGS*DataW-1:0] regs_o
);

  localparam int unsigned IdxW = ADDR_W - 2;

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DataW-1:0]  wdata_q;
  logic [StrbW-1:0]  strb_q;

  logic [IdxW-1:0]   idx;
  logic              err;
  logic              setup;
  logic              ready;
  logic              cnt_zero;
  logic              wr_en;
  logic [DataW-1:0]  rdata;

  assign setup = (state_q == StIdle) && apb.PSEL && !apb.PENABLE;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] cnt_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= 4'd0;
    end else if (setup) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if ((state_q == StAccess) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign cnt_zero = (cnt_q == 4'd0);
`else
  logic unused_wait_cycles;
  assign unused_wait_cycles = ^32'(WAIT_CYCLES);
  assign cnt_zero = 1'b1;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup) begin
      addr_q  <= apb.PADDR;
      write_q <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
      strb_q  <= apb.PSTRB;
    end
  end

  assign idx   = addr_q[ADDR_W-1:2];
  assign err   = (addr_q[1:0] != 2'b00) || (32'(idx) >= NUM_REGS);
  assign ready = (state_q == StAccess) && apb.PSEL && apb.PENABLE && cnt_zero;
  assign wr_en = ready && write_q && !err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping PSEL mid-access abandons the transfer without committing anything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (setup) state_d = StAccess;
      StAccess: if (!apb.PSEL || ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    apb.PREADY  = ready;
    apb.PSLVERR = ready && err;
    apb.PRDATA  = (ready && !write_q && !err) ? rdata : '0;
  end

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IdxW)
  ) u_regbank (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (wr_en),
    .idx   (idx),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .rdata (rdata),
    .regs  (regs_o)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: vector table through an APB master task plus
// hand-written protocol, reset and wait-state sequences.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef APB_SLAVE_WAIT_EN
  localparam int WaitExp = WAIT_CYCLES;
`else
  localparam int WaitExp = 0;
`endif

  logic                   PCLK = 1'b0;
  logic                   PRESET = 1'b1;
  logic [NUM_REGS*32-1:0] regs_o;

  apb_slave_regfile_if #(.ADDR_W(ADDR_W)) bus ();

  apb_slave_regfile #(
    .ADDR_W      (ADDR_W),
    .NUM_REGS    (NUM_REGS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus),
    .regs_o (regs_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[16];
  logic [31:0] exp_regs[NUM_REGS];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic drive_setup(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
  endtask

  // Called #1 after a rising edge; returns #1 after the completing edge with the bus idle,
  // so a following call issues its setup with no idle cycle in between.
  task automatic xfer(input vec_t v, input string name);
    exp_t e;
    int   waits;
    logic done;
    e.is_read = !v.wr;
    e.rdata   = v.rdata;
    e.err     = v.err;
    e.waits   = WaitExp;
    sb.push_back(e);
    drive_setup(v.wr, v.addr, v.wdata, v.strb);
    @(posedge PCLK);
    #1 bus.PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done && waits <= 40) begin
      @(negedge PCLK);
      if (bus.PREADY) begin
        done = 1'b1;
        e = sb.pop_front();
        if (e.is_read) chk({name, " prdata"}, bus.PRDATA, e.rdata);
        chk({name, " pslverr"}, 32'(bus.PSLVERR), 32'(e.err));
        chk({name, " wait states"}, 32'(waits), 32'(e.waits));
      end
      @(posedge PCLK);
      #1;
      if (!done) waits++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: PREADY not seen after %0d cycles, expected after %0d",
               name, waits, WaitExp);
      e = sb.pop_front();
    end
    drive_idle();
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      chk($sformatf("%s regs_o[%0d]", tag, i), regs_o[32*i +: 32], exp_regs[i]);
    end
  endtask

  initial begin
    vec_t v;
    drive_setup(1'b0, 12'h000, 32'h0, 4'h0);
    drive_idle();

    vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 12'h004, 32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 12'h004, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 12'h006, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 12'h01C, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 12'h01C, 32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[8]  = '{1'b1, 12'h01C, 32'hAAAAAAAA, 4'h0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 12'h01C, 32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[10] = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 12'h000, 32'hCAFEF00D, 4'hA, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 12'h000, 32'h0,        4'h0, 32'hCA00F000, 1'b0};
    vecs[13] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 12'h008, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 12'h008, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

    // Reset state
    #12;
    chk("reset pready", 32'(bus.PREADY), 32'h0);
    chk("reset pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("reset prdata", bus.PRDATA, 32'h0);
    chk("reset regs_o zero", 32'(regs_o == '0), 32'h1);
    @(posedge PCLK);
    #1 PRESET = 1'b0;

    foreach (vecs[i]) xfer(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < int'(NUM_REGS); i++) exp_regs[i] = 32'h0;
    exp_regs[0] = 32'hCA00F000;
    exp_regs[1] = 32'hDE22BE44;
    exp_regs[2] = 32'hA5A5A5A5;
    exp_regs[7] = 32'h12345678;
    chk_regs("after table");

    // PSEL dropped during access: nothing is written and PREADY never rises
    drive_setup(1'b1, 12'h010, 32'hFFFFFFFF, 4'hF);
    @(posedge PCLK);
    #1 drive_idle();
    @(negedge PCLK);
    chk("psel drop pready", 32'(bus.PREADY), 32'h0);
    @(posedge PCLK);
    #1;
    chk("psel drop reg4", regs_o[32*4 +: 32], 32'h0);
    v = '{1'b0, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0};
    xfer(v, "read after psel drop");

    // PENABLE asserted from idle without a setup phase is ignored
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 12'h014;
    bus.PWDATA  = 32'h55555555;
    bus.PSTRB   = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      chk($sformatf("penable in idle pready c%0d", c), 32'(bus.PREADY), 32'h0);
    end
    @(posedge PCLK);
    #1 drive_idle();
    chk("penable in idle reg5", regs_o[32*5 +: 32], 32'h0);
    v = '{1'b0, 12'h004, 32'h0, 4'h0, 32'hDE22BE44, 1'b0};
    xfer(v, "read after penable in idle");

    // Reset during the access phase of a write
    drive_setup(1'b1, 12'h00C, 32'h5A5A5A5A, 4'hF);
    @(posedge PCLK);
    #1 bus.PENABLE = 1'b1;
    #1 PRESET = 1'b1;
    #1;
    chk("mid reset pready", 32'(bus.PREADY), 32'h0);
    chk("mid reset pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("mid reset reg3", regs_o[32*3 +: 32], 32'h0);
    @(posedge PCLK);
    #1;
    drive_idle();
    PRESET = 1'b0;
    chk("mid reset reg3 after edge", regs_o[32*3 +: 32], 32'h0);
    for (int i = 0; i < int'(NUM_REGS); i++) exp_regs[i] = 32'h0;
    chk_regs("after mid reset");
    v = '{1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0};
    xfer(v, "read reg3 after reset");
    v = '{1'b1, 12'h018, 32'h0BADF00D, 4'hF, 32'h0, 1'b0};
    xfer(v, "write reg6 after reset");
    #1;
    chk("reg6 after reset write", regs_o[32*6 +: 32], 32'h0BADF00D);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
